// File: rtl/dead_time_monitor_pkg.sv
// Shared types for the PWM-leg dead-time monitor: FSM state, fault cause
// encoding, the counter-width macro and the gate normalisation helper.
`ifndef DTCOUNT_WIDTH
`define DTCOUNT_WIDTH 8
`endif

package dead_time_monitor_pkg;

  typedef enum logic [2:0] {
    OFF_INIT,
    A_ON,
    B_ON,
    DT_AB,
    DT_BA,
    FAULT
  } dtm_state_t;

  typedef enum logic [1:0] {
    DTM_NONE    = 2'd0,
    DTM_OVERLAP = 2'd1,
    DTM_SHORT_A = 2'd2,
    DTM_SHORT_B = 2'd3
  } dtm_fault_t;

  // A gate is "on" when its pin level equals its programmed active level.
  function automatic logic gate_on(input logic gate, input logic active_lvl);
    return gate == active_lvl;
  endfunction

endpackage

// File: rtl/dead_time_monitor_sat_counter.sv
// Saturating up-counter used to measure the both-off interval. start loads 1
// (the first both-off sample has already been seen), clr returns to 0, inc
// counts up and sticks at all-ones so a full count reads as "at least max".
module dead_time_monitor_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // Load / clear / saturating increment, start taking priority over clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= W'(1);
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dead_time_monitor.sv
// Dead-time monitor for one PWM leg. Sits between the dead-time generator and
// the gate-driver pins, measures the both-off interval before every turn-on,
// and latches a fault that forces both pins inactive until fault_clr.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   OFF_INIT | both off, no history since reset/enable/clear; counter 0
//   A_ON     | high-side active
//   B_ON     | low-side active
//   DT_AB    | both off after A; counting dead time before B turn-on
//   DT_BA    | both off after B; counting dead time before A turn-on
//   FAULT    | violation seen; waits for fault_clr (or enable low)
`ifndef DTCOUNT_WIDTH
`define DTCOUNT_WIDTH 8
`endif

module dead_time_monitor
  import dead_time_monitor_pkg::*;
#(
  parameter int DT_W       = `DTCOUNT_WIDTH,
  parameter bit FIRST_SKIP = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            gate_A,
  input  logic            gate_B,
  input  logic            logic_A,
  input  logic            logic_B,
  input  logic [DT_W-1:0] dtmin_A,
  input  logic [DT_W-1:0] dtmin_B,
  input  logic            fault_clr,
  output logic            gate_out_A,
  output logic            gate_out_B,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [DT_W-1:0] meas_dt_A,
  output logic [DT_W-1:0] meas_dt_B,
  output logic            meas_valid
);

  logic            a_q;
  logic            b_q;
  dtm_state_t      state_q;
  dtm_state_t      state_d;
  logic            cnt_start;
  logic            cnt_clr;
  logic            cnt_inc;
  logic [DT_W-1:0] cnt;
  logic            fault_set;
  dtm_fault_t      fault_cause;
  logic            fault_q;
  dtm_fault_t      fault_code_q;
  logic            ld_meas_a;
  logic            ld_meas_b;
  logic [DT_W-1:0] meas_a_q;
  logic [DT_W-1:0] meas_b_q;
  logic            meas_valid_q;
  logic            pass;

  // Register the normalised gate states once; all checks run on a_q/b_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= 1'b0;
      b_q <= 1'b0;
    end else begin
      a_q <= gate_on(gate_A, logic_A);
      b_q <= gate_on(gate_B, logic_B);
    end
  end

  dead_time_monitor_sat_counter #(
    .W (DT_W)
  ) u_dt_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (cnt_start),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .cnt     (cnt)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= OFF_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counter control, measurement loads and fault detection.
  // Overlap is tested before any per-state transition so it always wins.
  always_comb begin
    state_d     = state_q;
    cnt_start   = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    fault_set   = 1'b0;
    fault_cause = DTM_NONE;
    ld_meas_a   = 1'b0;
    ld_meas_b   = 1'b0;

    if (fault_clr || !enable) begin
      state_d = OFF_INIT;
      cnt_clr = 1'b1;
    end else if (state_q == FAULT) begin
      cnt_clr = 1'b1;
    end else if (a_q && b_q) begin
      state_d     = FAULT;
      cnt_clr     = 1'b1;
      fault_set   = 1'b1;
      fault_cause = DTM_OVERLAP;
    end else begin
      case (state_q)
        OFF_INIT: begin
          cnt_clr = 1'b1;
          if (a_q) begin
            state_d = A_ON;
            if (!FIRST_SKIP && (cnt < dtmin_A)) begin
              state_d     = FAULT;
              fault_set   = 1'b1;
              fault_cause = DTM_SHORT_A;
            end
          end else if (b_q) begin
            state_d = B_ON;
            if (!FIRST_SKIP && (cnt < dtmin_B)) begin
              state_d     = FAULT;
              fault_set   = 1'b1;
              fault_cause = DTM_SHORT_B;
            end
          end
        end

        A_ON: begin
          cnt_clr = 1'b1;
          if (!a_q && !b_q) begin
            state_d   = DT_AB;
            cnt_start = 1'b1;
          end else if (!a_q && b_q) begin
            // Hand-over with no both-off sample: a zero dead time for B.
            state_d   = B_ON;
            ld_meas_b = 1'b1;
            if (cnt < dtmin_B) begin
              state_d     = FAULT;
              fault_set   = 1'b1;
              fault_cause = DTM_SHORT_B;
            end
          end
        end

        B_ON: begin
          cnt_clr = 1'b1;
          if (!a_q && !b_q) begin
            state_d   = DT_BA;
            cnt_start = 1'b1;
          end else if (a_q && !b_q) begin
            state_d   = A_ON;
            ld_meas_a = 1'b1;
            if (cnt < dtmin_A) begin
              state_d     = FAULT;
              fault_set   = 1'b1;
              fault_cause = DTM_SHORT_A;
            end
          end
        end

        DT_AB: begin
          if (b_q) begin
            state_d   = B_ON;
            cnt_clr   = 1'b1;
            ld_meas_b = 1'b1;
            if (cnt < dtmin_B) begin
              state_d     = FAULT;
              fault_set   = 1'b1;
              fault_cause = DTM_SHORT_B;
            end
          end else if (a_q) begin
            state_d = A_ON;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end

        DT_BA: begin
          if (a_q) begin
            state_d   = A_ON;
            cnt_clr   = 1'b1;
            ld_meas_a = 1'b1;
            if (cnt < dtmin_A) begin
              state_d     = FAULT;
              fault_set   = 1'b1;
              fault_cause = DTM_SHORT_A;
            end
          end else if (b_q) begin
            state_d = B_ON;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end

        default: begin
          state_d = OFF_INIT;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // Latched fault: the first cause sticks until fault_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_q      <= 1'b0;
      fault_code_q <= DTM_NONE;
    end else if (fault_clr) begin
      fault_q      <= 1'b0;
      fault_code_q <= DTM_NONE;
    end else if (fault_set && !fault_q) begin
      fault_q      <= 1'b1;
      fault_code_q <= fault_cause;
    end
  end

  // Measurement capture with a one-cycle valid strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meas_a_q     <= '0;
      meas_b_q     <= '0;
      meas_valid_q <= 1'b0;
    end else begin
      meas_valid_q <= ld_meas_a || ld_meas_b;
      if (ld_meas_a) begin
        meas_a_q <= cnt;
      end
      if (ld_meas_b) begin
        meas_b_q <= cnt;
      end
    end
  end

  // reset_n is part of the mask so the pins go inactive the moment reset asserts.
  assign pass       = reset_n && enable && !fault_q;
  assign gate_out_A = pass ? gate_A : ~logic_A;
  assign gate_out_B = pass ? gate_B : ~logic_B;

  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign meas_dt_A  = meas_a_q;
  assign meas_dt_B  = meas_b_q;
  assign meas_valid = meas_valid_q;

endmodule

// File: tb/tb_dead_time_monitor.sv
// Bench for dead_time_monitor (DT_W = 4): a table of PWM scenarios, a few
// hand-timed corner sequences, then random waveforms against a reference model.
module tb_dead_time_monitor;

  localparam int W  = 4;
  localparam int MX = 15;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b1;
  logic         gate_A = 1'b1;
  logic         gate_B = 1'b0;
  logic         logic_A = 1'b1;
  logic         logic_B = 1'b1;
  logic [W-1:0] dtmin_A = '0;
  logic [W-1:0] dtmin_B = '0;
  logic         fault_clr = 1'b0;
  logic         gate_out_A;
  logic         gate_out_B;
  logic         fault;
  logic [1:0]   fault_code;
  logic [W-1:0] meas_dt_A;
  logic [W-1:0] meas_dt_B;
  logic         meas_valid;

  int n_cmp = 0;
  int n_bad = 0;

  dead_time_monitor #(
    .DT_W       (W),
    .FIRST_SKIP (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .gate_A     (gate_A),
    .gate_B     (gate_B),
    .logic_A    (logic_A),
    .logic_B    (logic_B),
    .dtmin_A    (dtmin_A),
    .dtmin_B    (dtmin_B),
    .fault_clr  (fault_clr),
    .gate_out_A (gate_out_A),
    .gate_out_B (gate_out_B),
    .fault      (fault),
    .fault_code (fault_code),
    .meas_dt_A  (meas_dt_A),
    .meas_dt_B  (meas_dt_B),
    .meas_valid (meas_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got no end, required end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_gates(input bit a_on, input bit b_on);
    gate_A = a_on ? logic_A : !logic_A;
    gate_B = b_on ? logic_B : !logic_B;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    enable    = 1'b1;
    fault_clr = 1'b0;
    set_gates(0, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- table of PWM scenarios ----------------
  typedef struct {
    bit la;
    bit lb;
    int dma;
    int dmb;
    int gab;
    int gba;
    int e_mb;
    int e_ma;
    bit e_f;
    int e_code;
  } row_t;

  row_t rows[8];

  // ---------------- reference model ----------------
  int m_aq, m_bq, m_last, m_gap, m_frozen, m_fault, m_code, m_meas_a, m_meas_b, m_valid;

  task automatic model_reset();
    m_aq = 0; m_bq = 0; m_last = 0; m_gap = 0; m_frozen = 0;
    m_fault = 0; m_code = 0; m_meas_a = 0; m_meas_b = 0; m_valid = 0;
  endtask

  task automatic raise(input int code);
    m_frozen = 1;
    if (m_fault == 0) begin
      m_fault = 1;
      m_code  = code;
    end
  endtask

  // One clock edge: m_last = last gate seen on (0 = none since reset/enable/clear),
  // m_gap = both-off samples seen since that gate went off.
  task automatic model_step();
    int dt;
    int on_now;
    m_valid = 0;
    if (fault_clr) begin
      m_frozen = 0; m_fault = 0; m_code = 0; m_last = 0; m_gap = 0;
    end else if (!enable) begin
      m_frozen = 0; m_last = 0; m_gap = 0;
    end else if (m_frozen == 0) begin
      if (m_aq != 0 && m_bq != 0) begin
        raise(1);
      end else if (m_aq == 0 && m_bq == 0) begin
        if (m_last != 0) m_gap++;
      end else begin
        on_now = (m_aq != 0) ? 1 : 2;
        if (m_last == 0 || on_now == m_last) begin
          m_last = on_now;
          m_gap  = 0;
        end else begin
          dt = (m_gap > MX) ? MX : m_gap;
          m_valid = 1;
          m_last  = on_now;
          m_gap   = 0;
          if (on_now == 1) begin
            m_meas_a = dt;
            if (dt < int'(dtmin_A)) raise(2);
          end else begin
            m_meas_b = dt;
            if (dt < int'(dtmin_B)) raise(3);
          end
        end
      end
    end
    m_aq = (gate_A == logic_A) ? 1 : 0;
    m_bq = (gate_B == logic_B) ? 1 : 0;
  endtask

  initial begin
    int run_left;
    int pat;
    bit exp_ga;
    bit exp_gb;

    rows[0] = '{1, 1, 5, 5, 8, 8, 8, 8, 0, 0};
    rows[1] = '{1, 1, 5, 5, 3, 8, 3, 0, 1, 3};
    rows[2] = '{0, 0, 6, 6, 6, 6, 6, 6, 0, 0};
    rows[3] = '{1, 1, 10, 10, 40, 40, 15, 15, 0, 0};
    rows[4] = '{1, 1, 7, 5, 8, 2, 8, 2, 1, 2};
    rows[5] = '{1, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    rows[6] = '{1, 1, 15, 15, 20, 14, 15, 14, 1, 2};
    rows[7] = '{0, 0, 6, 6, 5, 6, 5, 0, 1, 3};

    // Reset state, with gate_A driven active so the pin mask is visible.
    #2;
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_meas_a", meas_dt_A, 0);
    chk("rst_meas_b", meas_dt_B, 0);
    chk("rst_valid", meas_valid, 0);
    chk("rst_pin_a", gate_out_A, 0);
    chk("rst_pin_b", gate_out_B, 0);

    // Table scenarios: A on, gap, B on, gap, A on; then check the captured state.
    for (int r = 0; r < 8; r++) begin
      logic_A = rows[r].la;
      logic_B = rows[r].lb;
      dtmin_A = W'(rows[r].dma);
      dtmin_B = W'(rows[r].dmb);
      do_reset();
      cyc(2);
      set_gates(1, 0); cyc(6);
      set_gates(0, 0); cyc(rows[r].gab);
      set_gates(0, 1); cyc(6);
      set_gates(0, 0); cyc(rows[r].gba);
      set_gates(1, 0); cyc(4);
      chk($sformatf("row%0d_meas_b", r), meas_dt_B, rows[r].e_mb);
      chk($sformatf("row%0d_meas_a", r), meas_dt_A, rows[r].e_ma);
      chk($sformatf("row%0d_fault", r), fault, rows[r].e_f);
      chk($sformatf("row%0d_code", r), fault_code, rows[r].e_code);
      chk($sformatf("row%0d_pin_a", r), gate_out_A, rows[r].e_f ? !rows[r].la : rows[r].la);
    end

    // Fault latency: short dead time before B; fault two edges after B input rises.
    logic_A = 1; logic_B = 1; dtmin_A = 5; dtmin_B = 5;
    do_reset();
    set_gates(1, 0); cyc(4);
    set_gates(0, 0); cyc(3);
    set_gates(0, 1);
    cyc(1);
    chk("lat_k_fault", fault, 0);
    chk("lat_k_pin_b", gate_out_B, 1);
    cyc(1);
    chk("lat_k1_fault", fault, 1);
    chk("lat_k1_code", fault_code, 3);
    chk("lat_k1_pin_b", gate_out_B, 0);
    chk("lat_k1_valid", meas_valid, 1);
    chk("lat_k1_meas_b", meas_dt_B, 3);
    cyc(1);
    chk("lat_valid_pulse", meas_valid, 0);

    // Overlap: first cause sticks through a later short, then clear resumes pins.
    do_reset();
    set_gates(1, 0); cyc(3);
    set_gates(1, 1); cyc(1);
    set_gates(1, 0); cyc(3);
    chk("ovl_fault", fault, 1);
    chk("ovl_code", fault_code, 1);
    set_gates(0, 0); cyc(2);
    set_gates(0, 1); cyc(4);
    chk("ovl_code_kept", fault_code, 1);
    chk("ovl_pin_b_masked", gate_out_B, 0);
    fault_clr = 1; cyc(1); fault_clr = 0;
    chk("ovl_clr_fault", fault, 0);
    chk("ovl_clr_code", fault_code, 0);
    chk("ovl_clr_pin_b", gate_out_B, 1);
    cyc(4);
    chk("ovl_after_clr_fault", fault, 0);

    // Clear while overlap persists: fault drops for one cycle, then re-detected.
    do_reset();
    set_gates(1, 1); cyc(3);
    chk("pers_fault", fault, 1);
    fault_clr = 1; cyc(1); fault_clr = 0;
    chk("pers_clr_fault", fault, 0);
    cyc(1);
    chk("pers_redetect", fault, 1);
    chk("pers_code", fault_code, 1);

    // enable low: fault holds, clear honoured, pins stay masked until enable.
    enable = 0; set_gates(1, 0); cyc(2);
    chk("en_fault_hold", fault, 1);
    fault_clr = 1; cyc(1); fault_clr = 0;
    chk("en_clr_fault", fault, 0);
    chk("en_pin_a_masked", gate_out_A, 0);
    enable = 1; #1;
    chk("en_pin_a_pass", gate_out_A, 1);
    cyc(4);
    chk("en_first_on_unchecked", fault, 0);

    // Reset while in FAULT, then first turn-on unchecked even with dtmin_A = 7.
    set_gates(1, 1); cyc(3);
    set_gates(1, 0);
    #2; reset_n = 0; #1;
    chk("rstf_fault", fault, 0);
    chk("rstf_code", fault_code, 0);
    chk("rstf_pin_a", gate_out_A, 0);
    @(negedge clk); reset_n = 1;
    dtmin_A = 7;
    set_gates(0, 0); cyc(2);
    set_gates(1, 0); cyc(5);
    chk("rstf_skip_fault", fault, 0);
    chk("rstf_skip_pin_a", gate_out_A, 1);
    #2; reset_n = 0; #1;
    chk("rst_live_pin_a", gate_out_A, 0);
    @(negedge clk); reset_n = 1;

    // Random waveforms against the model.
    do_reset();
    model_reset();
    run_left = 0;
    pat = 0;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 399) == 0) logic_A = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 399) == 0) logic_B = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) dtmin_A = W'($urandom_range(0, 12));
      if ($urandom_range(0, 99) == 0) dtmin_B = W'($urandom_range(0, 12));
      fault_clr = ($urandom_range(0, 49) == 0);
      if (enable) enable = ($urandom_range(0, 149) != 0);
      else        enable = ($urandom_range(0, 3) == 0);
      if (run_left == 0) begin
        pat = $urandom_range(0, 7);
        if (pat == 7 && $urandom_range(0, 3) != 0) pat = 6;
        run_left = $urandom_range(1, 20);
      end
      run_left--;
      case (pat)
        0, 1, 2: set_gates(1, 0);
        3, 4, 5: set_gates(0, 1);
        6:       set_gates(0, 0);
        default: set_gates(1, 1);
      endcase
      @(posedge clk);
      model_step();
      #1;
      exp_ga = (enable && m_fault == 0) ? gate_A : !logic_A;
      exp_gb = (enable && m_fault == 0) ? gate_B : !logic_B;
      chk($sformatf("rnd%0d_fault", c), fault, m_fault);
      chk($sformatf("rnd%0d_code", c), fault_code, m_code);
      chk($sformatf("rnd%0d_meas_a", c), meas_dt_A, m_meas_a);
      chk($sformatf("rnd%0d_meas_b", c), meas_dt_B, m_meas_b);
      chk($sformatf("rnd%0d_valid", c), meas_valid, m_valid);
      chk($sformatf("rnd%0d_pin_a", c), gate_out_A, exp_ga);
      chk($sformatf("rnd%0d_pin_b", c), gate_out_B, exp_gb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
